// File: rtl/cpu_pkg.sv
// cpu_pkg: shared SRAM interface widths and the owner tag carried
// alongside each SRAM read while its data is in flight.
//   SRAM_AW / SRAM_DW : SRAM address / data width
//   OWNER_INST / OWNER_DATA : which requester a read belongs to
//   owner_tag_t : {vld, owner} entry of the owner-tag pipeline
package cpu_pkg;

    localparam int unsigned SRAM_AW = 32;
    localparam int unsigned SRAM_DW = 32;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef struct packed {
        logic vld;
        logic owner;
    } owner_tag_t;

    // Drop an inst-owned tag when fetch is redirected; data tags pass unchanged.
    function automatic owner_tag_t clear_inst(input owner_tag_t tag, input logic cancel);
        owner_tag_t res;
        res = tag;
        if (cancel && (tag.owner == OWNER_INST)) begin
            res.vld = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_owner_pipe.sv
// arb_owner_pipe: LAT-deep shift register of owner tags that tracks which
// requester owns the SRAM read data returning LAT cycles after issue.
//   clk, reset  : clock, async active-high reset (all entries invalid)
//   push_tag    : tag for the access issued this cycle
//   inst_cancel : invalidates every inst-owned entry, including push_tag
//   out_tag     : tag matching the SRAM read data presented this cycle
module arb_owner_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  owner_tag_t push_tag,
    input  logic       inst_cancel,
    output owner_tag_t out_tag
);

    owner_tag_t stage [LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= clear_inst(push_tag, inst_cancel);
            for (int unsigned i = 1; i < LAT; i++) begin
                stage[i] <= clear_inst(stage[i-1], inst_cancel);
            end
        end
    end

    assign out_tag = stage[LAT-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// fetch stage (read-only) and the memory stage (read/write).
//   clk, reset                       : clock, async active-high reset
//   inst_req/addr/cancel             : fetch read request, redirect flush
//   inst_gnt/rvalid/rdata            : fetch grant and returned word
//   data_req/wen/addr/wdata          : memory-stage request (wen==0 -> read)
//   data_gnt/rvalid/rdata            : memory-stage grant and load word
//   sram_en/wen/addr/wdata, sram_rdata : SRAM interface
// Data has fixed priority over inst; after STARVE_MAX consecutive contested
// losses inst wins the next contested cycle. Reads are fully pipelined and
// return LAT cycles after grant, routed by the owner-tag pipeline.
module sram_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned LAT        = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req,
    input  logic [SRAM_AW-1:0] inst_addr,
    input  logic               inst_cancel,
    output logic               inst_gnt,
    output logic               inst_rvalid,
    output logic [SRAM_DW-1:0] inst_rdata,
    input  logic               data_req,
    input  logic [3:0]         data_wen,
    input  logic [SRAM_AW-1:0] data_addr,
    input  logic [SRAM_DW-1:0] data_wdata,
    output logic               data_gnt,
    output logic               data_rvalid,
    output logic [SRAM_DW-1:0] data_rdata,
    output logic               sram_en,
    output logic [3:0]         sram_wen,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata
);

    logic       inst_rq;
    logic       data_rq;
    logic       inst_win;
    logic       data_win;
    logic       starved;
    logic [3:0] starve_cnt;
    owner_tag_t push_tag;
    owner_tag_t out_tag;

    // Requests are masked while reset is held so no grant or SRAM access
    // escapes during reset.
    assign inst_rq = inst_req & ~reset;
    assign data_rq = data_req & ~reset;
    assign starved = (starve_cnt == 4'(STARVE_MAX));

    always_comb begin
        inst_win   = inst_rq & (~data_rq | starved);
        data_win   = data_rq & ~inst_win;
        sram_en    = inst_win | data_win;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (data_win) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_win) begin
            sram_addr  = inst_addr;
        end
    end

    assign inst_gnt = inst_win;
    assign data_gnt = data_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!inst_req || inst_win) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Only reads occupy a tag slot; writes complete at grant.
    always_comb begin
        push_tag       = '0;
        push_tag.vld   = sram_en & (sram_wen == '0);
        push_tag.owner = data_win ? OWNER_DATA : OWNER_INST;
    end

    arb_owner_pipe #(
        .LAT (LAT)
    ) u_owner_pipe (
        .clk         (clk),
        .reset       (reset),
        .push_tag    (push_tag),
        .inst_cancel (inst_cancel),
        .out_tag     (out_tag)
    );

    assign inst_rvalid = out_tag.vld & (out_tag.owner == OWNER_INST);
    assign data_rvalid = out_tag.vld & (out_tag.owner == OWNER_DATA);
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: four instances (LAT=1..4) share one
// stimulus stream. The issue side predicts grants and SRAM outputs and
// queues expected responses; a separate monitor pops and compares rvalid
// and rdata each cycle.
module tb_sram_port_arbiter;

    localparam int          NDUT = 4;
    localparam int unsigned SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_cancel;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] sram_rdata;

    logic        ig_w   [NDUT];
    logic        dg_w   [NDUT];
    logic        irv_w  [NDUT];
    logic        drv_w  [NDUT];
    logic        en_w   [NDUT];
    logic [3:0]  wen_w  [NDUT];
    logic [31:0] addr_w [NDUT];
    logic [31:0] wd_w   [NDUT];
    logic [31:0] ird_w  [NDUT];
    logic [31:0] drd_w  [NDUT];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Hand-computed expectations for directed cycles ({inst,data}); -1 = none.
    int h_eg  = -1;
    int h_rv1 = -1;
    int h_rv2 = -1;

    logic seen_ig = 1'b0;
    logic seen_dg = 1'b0;

    typedef struct {
        bit owner;
        int due;
    } resp_t;

    resp_t sb [NDUT][$];
    int unsigned starve_m = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sram_port_arbiter #(
            .LAT        (g + 1),
            .STARVE_MAX (SMAX)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .inst_req    (inst_req),
            .inst_addr   (inst_addr),
            .inst_cancel (inst_cancel),
            .inst_gnt    (ig_w[g]),
            .inst_rvalid (irv_w[g]),
            .inst_rdata  (ird_w[g]),
            .data_req    (data_req),
            .data_wen    (data_wen),
            .data_addr   (data_addr),
            .data_wdata  (data_wdata),
            .data_gnt    (dg_w[g]),
            .data_rvalid (drv_w[g]),
            .data_rdata  (drd_w[g]),
            .sram_en     (en_w[g]),
            .sram_wen    (wen_w[g]),
            .sram_addr   (addr_w[g]),
            .sram_wdata  (wd_w[g]),
            .sram_rdata  (sram_rdata)
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM read data is a known function of the cycle number.
    assign sram_rdata = 32'hC0DE0000 + 32'(cyc);

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d cyc=%0d got=%h expected=%h", name, g + 1, cyc, act, exp);
        end
    endtask

    // Issue side: predict grant and SRAM outputs, queue expected responses.
    always @(negedge clk) begin : issue_side
        logic        ei;
        logic        ed;
        logic [3:0]  ewen;
        logic [31:0] eaddr;
        logic [31:0] ewd;
        resp_t       keep [$];
        if (reset) begin
            ei = 1'b0;
            ed = 1'b0;
        end else begin
            ei = inst_req && (!data_req || starve_m == SMAX);
            ed = data_req && !ei;
        end
        ewen  = ed ? data_wen : 4'd0;
        eaddr = ei ? inst_addr : (ed ? data_addr : 32'd0);
        ewd   = ed ? data_wdata : 32'd0;
        for (int g = 0; g < NDUT; g++) begin
            chk("grant_en_wen", g, 32'({ig_w[g], dg_w[g], en_w[g], wen_w[g]}),
                32'({ei, ed, ei | ed, ewen}));
            chk("sram_addr", g, addr_w[g], eaddr);
            chk("sram_wdata", g, wd_w[g], ewd);
        end
        if (h_eg >= 0) begin
            chk("hand_grant", 0, 32'({ig_w[0], dg_w[0]}), 32'(h_eg));
        end
        if (reset) begin
            for (int g = 0; g < NDUT; g++) sb[g].delete();
            starve_m = 0;
        end else begin
            for (int g = 0; g < NDUT; g++) begin
                if (inst_cancel) begin
                    keep.delete();
                    for (int k = 0; k < sb[g].size(); k++) begin
                        if (sb[g][k].owner || sb[g][k].due <= cyc) keep.push_back(sb[g][k]);
                    end
                    sb[g] = keep;
                end
                if ((ei || ed) && ewen == 4'd0 && !(ei && inst_cancel)) begin
                    sb[g].push_back('{ed, cyc + g + 1});
                end
            end
            if (!inst_req || ei) starve_m = 0;
            else if (starve_m != SMAX) starve_m = starve_m + 1;
        end
    end

    // Monitor: pop the expected response due this cycle and compare.
    always @(negedge clk) begin : response_monitor
        logic [1:0] erv;
        for (int g = 0; g < NDUT; g++) begin
            erv = 2'b00;
            if (!reset && sb[g].size() > 0 && sb[g][0].due == cyc) begin
                erv = sb[g][0].owner ? 2'b01 : 2'b10;
                void'(sb[g].pop_front());
            end
            chk("rvalid", g, 32'({irv_w[g], drv_w[g]}), 32'(erv));
            if (erv[1]) chk("inst_rdata", g, ird_w[g], 32'hC0DE0000 + 32'(cyc));
            if (erv[0]) chk("data_rdata", g, drd_w[g], 32'hC0DE0000 + 32'(cyc));
        end
        if (h_rv1 >= 0) chk("hand_rvalid", 0, 32'({irv_w[0], drv_w[0]}), 32'(h_rv1));
        if (h_rv2 >= 0) chk("hand_rvalid", 1, 32'({irv_w[1], drv_w[1]}), 32'(h_rv2));
    end

    task automatic drive(input logic rst, input logic ir, input logic [31:0] ia, input logic ic,
                         input logic dr, input logic [3:0] dw, input logic [31:0] da,
                         input logic [31:0] dd, input int eg, input int rv1, input int rv2);
        reset       = rst;
        inst_req    = ir;
        inst_addr   = ia;
        inst_cancel = ic;
        data_req    = dr;
        data_wen    = dw;
        data_addr   = da;
        data_wdata  = dd;
        h_eg        = eg;
        h_rv1       = rv1;
        h_rv2       = rv2;
        @(negedge clk);
        seen_ig = ig_w[0];
        seen_dg = dg_w[0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int rv1, input int rv2);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 0, rv1, rv2);
    endtask

    task automatic both_rd(input logic rst, input int eg, input int rv1, input int rv2);
        drive(rst, 1'b1, 32'h0000_1000, 1'b0, 1'b1, 4'd0, 32'h0000_2000, 32'd0, eg, rv1, rv2);
    endtask

    initial begin : stimulus
        logic        ir_cur;
        logic        dr_cur;
        logic [31:0] ia_cur;
        logic [31:0] da_cur;
        logic [3:0]  dw_cur;
        logic [31:0] dd_cur;
        logic        ic_cur;

        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 0, 0, 0);
        drive(1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 4'd0, 32'd8, 32'd0, 0, 0, 0);
        idle(0, 0);

        // Single fetch read.
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 2, 0, 0);
        idle(2, 0);
        idle(0, 2);
        idle(0, 0);

        // Contention: data x4, inst, data.
        both_rd(1'b0, 1, 0, 0);
        both_rd(1'b0, 1, 1, 0);
        both_rd(1'b0, 1, 1, 1);
        both_rd(1'b0, 1, 1, 1);
        both_rd(1'b0, 2, 1, 1);
        both_rd(1'b0, 1, 2, 1);
        idle(1, 2);
        idle(0, 1);
        idle(0, 0);

        // Partial store: no response.
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 0);
        idle(0, 0);
        idle(0, 0);
        idle(0, 0);

        // Redirect drops both in-flight fetch reads; a later data read survives.
        drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 2, 0, 0);
        drive(1'b0, 1'b1, 32'h0000_0044, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 2, -1, 0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 4'd0, 32'h0000_0300, 32'd0, 1, 0, 0);
        idle(1, 0);
        idle(0, 1);
        idle(0, 0);

        // Reset mid-operation: in-flight data lost, starvation count restarts.
        both_rd(1'b0, 1, 0, 0);
        both_rd(1'b0, 1, 1, 0);
        both_rd(1'b0, 1, 1, 1);
        both_rd(1'b1, 0, 0, 0);
        both_rd(1'b0, 1, 0, 0);
        both_rd(1'b0, 1, 1, 0);
        both_rd(1'b0, 1, 1, 1);
        both_rd(1'b0, 1, 1, 1);
        both_rd(1'b0, 2, 1, 1);
        idle(2, 1);
        idle(0, 2);
        idle(0, 0);
        idle(0, 0);
        idle(0, 0);

        // Random traffic; requests held until granted.
        ir_cur = 1'b0;
        dr_cur = 1'b0;
        ia_cur = '0;
        da_cur = '0;
        dw_cur = '0;
        dd_cur = '0;
        seen_ig = 1'b0;
        seen_dg = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!ir_cur || seen_ig) begin
                ir_cur = 1'($urandom_range(0, 1));
                ia_cur = $urandom & 32'hFFFF_FFFC;
            end
            if (!dr_cur || seen_dg) begin
                dr_cur = 1'($urandom_range(0, 1));
                da_cur = $urandom & 32'hFFFF_FFFC;
                dw_cur = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
                dd_cur = $urandom;
            end
            ic_cur = ($urandom_range(0, 15) == 0);
            drive(1'b0, ir_cur, ia_cur, ic_cur, dr_cur, dw_cur, da_cur, dd_cur, -1, -1, -1);
        end
        for (int i = 0; i < 6; i++) idle(-1, -1);

        for (int g = 0; g < NDUT; g++) begin
            chk("drain", g, 32'(sb[g].size()), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
